// File: rtl/core_dbg_iface_pkg.sv
// Shared types and constants for the core debug interface: register offsets,
// DBGSC/DRUNCTRL bit positions and the injected-instruction bundle.
package core;

  localparam int ADDR_WIDTH      = 32;
  localparam int INSN_ADDR_START = 2;
  localparam int INSN_W          = 32;
  localparam int NUM_SLOTS       = 4;
  localparam int SLOT_ADDR_W     = ADDR_WIDTH - INSN_ADDR_START;

  typedef enum logic [3:0] {
    REG_DBGSC    = 4'd0,
    REG_DRUNCTRL = 4'd1,
    REG_ITR0     = 4'd2,
    REG_ITR1     = 4'd3,
    REG_ITR2     = 4'd4,
    REG_ITR3     = 4'd5,
    REG_DTR_HI   = 4'd6,
    REG_DTR_LO   = 4'd7
  } DbgIfaceReg;

  localparam int DBGSC_HALT  = 0;
  localparam int DBGSC_BUSY  = 1;
  localparam int DBGSC_ERR   = 2;
  localparam int DRUN_RESUME = 0;
  localparam int DRUN_STEP   = 1;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_ADDR_W-1:0] addr;
    logic [INSN_W-1:0]      insn;
  } InsnBundle;

  // Word address tagged on slot idx of an injected bundle stream.
  function automatic logic [SLOT_ADDR_W-1:0] slot_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [1:0]            idx
  );
    return base[ADDR_WIDTH-1:INSN_ADDR_START] + SLOT_ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/core_dbg_iface_if.sv
// External debug bus: write/read strobes, offset, data and busy indication.
interface core_dbg_iface_if;

  logic        dbg_wr_en;
  logic        dbg_rd_en;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_busy;

  modport master (
    output dbg_wr_en, dbg_rd_en, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_busy
  );

  modport slave (
    input  dbg_wr_en, dbg_rd_en, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_busy
  );

endinterface

// File: rtl/core_dbg_itr_seq.sv
// ITR injection sequencer: walks the four ITR slots into decode with a
// valid/ready handshake and pulses done the cycle after the last acceptance.
module core_dbg_itr_seq
  import core::*;
#(
  parameter logic [ADDR_WIDTH-1:0] ITR_BASE_ADDR = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_SLOTS-1:0][INSN_W-1:0] itr,
  input  logic                           itr_ready,
  output InsnBundle                      itr_out,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_e;

  seq_state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    busy    = 1'b0;
    itr_out = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          idx_d   = 2'd0;
        end
      end
      ISSUE: begin
        busy          = 1'b1;
        itr_out.valid = 1'b1;
        itr_out.insn  = itr[idx_q];
        itr_out.addr  = slot_addr(ITR_BASE_ADDR, idx_q);
        if (itr_ready) begin
          if (idx_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over a same-cycle final acceptance, so no done follows a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/core_dbg_iface.sv
// Core debug register block: decodes debug-bus accesses, drives halt/resume/
// step controls, holds the 64-bit DTR and launches ITR injection.
module core_dbg_iface
  import core::*;
#(
  parameter logic [ADDR_WIDTH-1:0] ITR_BASE_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  core_dbg_iface_if.slave        dbg,
  input  logic                   core_halted,
  output logic                   halt_req,
  output logic                   resume_pulse,
  output logic                   step_pulse,
  output InsnBundle              itr_out,
  input  logic                   itr_ready,
  output logic                   itr_done,
  output logic                   itr_err,
  input  logic                   core_dtr_wr_en,
  input  logic [63:0]            core_dtr_wdata,
  output logic [63:0]            core_dtr_rdata
);

  logic                           halt_q;
  logic                           err_q;
  logic                           resume_q;
  logic                           step_q;
  logic [63:0]                    dtr_q;
  logic [NUM_SLOTS-1:0][INSN_W-1:0] itr_q;
  logic [31:0]                    rdata_q;
  logic [31:0]                    rdata_d;

  logic       busy;
  logic       wr_dbgsc, wr_drun, wr_itr, wr_itr3, wr_hi, wr_lo;
  logic       itr_load, seq_start, err_set;
  logic [1:0] itr_idx;

  always_comb begin
    wr_dbgsc = 1'b0;
    wr_drun  = 1'b0;
    wr_itr   = 1'b0;
    wr_itr3  = 1'b0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    if (dbg.dbg_wr_en) begin
      case (dbg.dbg_addr)
        REG_DBGSC:    wr_dbgsc = 1'b1;
        REG_DRUNCTRL: wr_drun  = 1'b1;
        REG_ITR0,
        REG_ITR1,
        REG_ITR2:     wr_itr   = 1'b1;
        REG_ITR3: begin
          wr_itr  = 1'b1;
          wr_itr3 = 1'b1;
        end
        REG_DTR_HI:   wr_hi    = 1'b1;
        REG_DTR_LO:   wr_lo    = 1'b1;
        default: ;
      endcase
    end
  end

  // Offsets 2..5 map to slots 0..3.
  assign itr_idx   = {~dbg.dbg_addr[1], dbg.dbg_addr[0]};
  assign itr_load  = wr_itr && !busy;
  assign seq_start = wr_itr3 && !busy && core_halted;
  assign err_set   = (wr_itr && busy) || (wr_itr3 && !busy && !core_halted);

  always_comb begin
    rdata_d = '0;
    case (dbg.dbg_addr)
      REG_DBGSC:  rdata_d = {29'b0, err_q, busy, halt_q};
      REG_DTR_HI: rdata_d = dtr_q[63:32];
      REG_DTR_LO: rdata_d = dtr_q[31:0];
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
      resume_q <= 1'b0;
      step_q   <= 1'b0;
      dtr_q    <= '0;
      itr_q    <= '0;
      rdata_q  <= '0;
    end else begin
      resume_q <= wr_drun && dbg.dbg_wdata[DRUN_RESUME] && core_halted;
      step_q   <= wr_drun && dbg.dbg_wdata[DRUN_STEP] && core_halted;
      if (wr_dbgsc) halt_q <= dbg.dbg_wdata[DBGSC_HALT];
      if (err_set) begin
        err_q <= 1'b1;
      end else if (wr_dbgsc && dbg.dbg_wdata[DBGSC_ERR]) begin
        err_q <= 1'b0;
      end
      if (itr_load) itr_q[itr_idx] <= dbg.dbg_wdata;
      // The core side owns the whole DTR when both sides write together.
      if (core_dtr_wr_en) begin
        dtr_q <= core_dtr_wdata;
      end else if (wr_hi) begin
        dtr_q[63:32] <= dbg.dbg_wdata;
      end else if (wr_lo) begin
        dtr_q[31:0] <= dbg.dbg_wdata;
      end
      if (dbg.dbg_rd_en) rdata_q <= rdata_d;
    end
  end

  core_dbg_itr_seq #(
    .ITR_BASE_ADDR(ITR_BASE_ADDR)
  ) u_itr_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (seq_start),
    .itr      (itr_q),
    .itr_ready(itr_ready),
    .itr_out  (itr_out),
    .busy     (busy),
    .done     (itr_done)
  );

  assign dbg.dbg_rdata  = rdata_q;
  assign dbg.dbg_busy   = busy;
  assign halt_req       = halt_q;
  assign itr_err        = err_q;
  assign resume_pulse   = resume_q;
  assign step_pulse     = step_q;
  assign core_dtr_rdata = dtr_q;

endmodule

// File: tb/tb_core_dbg_iface.sv
// Bench for core_dbg_iface: directed scenarios plus randomized traffic, all
// compared against a transaction-level model of the register block.
module tb_core_dbg_iface;
  import core::*;

  localparam logic [31:0] BASE = 32'h0000_1000;

  typedef struct {
    logic [31:0] insn;
    logic [29:0] addr;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_halted;
  logic        halt_req, resume_pulse, step_pulse;
  InsnBundle   itr_out;
  logic        itr_ready, itr_done, itr_err;
  logic        core_dtr_wr_en;
  logic [63:0] core_dtr_wdata, core_dtr_rdata;

  core_dbg_iface_if bus ();

  core_dbg_iface #(.ITR_BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .rst           (rst),
    .dbg           (bus),
    .core_halted   (core_halted),
    .halt_req      (halt_req),
    .resume_pulse  (resume_pulse),
    .step_pulse    (step_pulse),
    .itr_out       (itr_out),
    .itr_ready     (itr_ready),
    .itr_done      (itr_done),
    .itr_err       (itr_err),
    .core_dtr_wr_en(core_dtr_wr_en),
    .core_dtr_wdata(core_dtr_wdata),
    .core_dtr_rdata(core_dtr_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model state: what the outputs should show right now.
  logic        m_halt, m_err, m_resume, m_step, m_done;
  logic [63:0] m_dtr;
  logic [31:0] m_itr [4];
  logic [31:0] m_rdata;
  bundle_t     m_q[$];

  bundle_t     acc[$];
  int          done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_halt = 0; m_err = 0; m_resume = 0; m_step = 0; m_done = 0;
    m_dtr = '0; m_rdata = '0;
    for (int i = 0; i < 4; i++) m_itr[i] = '0;
    m_q.delete();
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'd0:    return {29'b0, m_err, m_q.size() != 0, m_halt};
      4'd6:    return m_dtr[63:32];
      4'd7:    return m_dtr[31:0];
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_outputs();
    chk("halt_req", halt_req, m_halt);
    chk("itr_err", itr_err, m_err);
    chk("dtr", core_dtr_rdata, m_dtr);
    chk("rdata", bus.dbg_rdata, m_rdata);
    chk("busy", bus.dbg_busy, m_q.size() != 0);
    chk("valid", itr_out.valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("insn", itr_out.insn, m_q[0].insn);
      chk("addr", itr_out.addr, m_q[0].addr);
    end
    chk("resume", resume_pulse, m_resume);
    chk("step", step_pulse, m_step);
    chk("done", itr_done, m_done);
  endtask

  // Check current outputs, advance the model by the inputs now driven, clock once.
  task automatic step_cyc();
    logic        busy;
    logic [31:0] n_rdata;
    logic [31:0] d;
    logic [3:0]  a;
    check_outputs();
    if (itr_out.valid && itr_ready && !rst) acc.push_back('{itr_out.insn, itr_out.addr});
    if (itr_done) done_cnt++;
    if (rst) begin
      model_reset();
    end else begin
      busy    = m_q.size() != 0;
      a       = bus.dbg_addr;
      d       = bus.dbg_wdata;
      n_rdata = bus.dbg_rd_en ? m_read(a) : m_rdata;
      m_resume = bus.dbg_wr_en && a == 4'd1 && d[0] && core_halted;
      m_step   = bus.dbg_wr_en && a == 4'd1 && d[1] && core_halted;
      m_done   = busy && itr_ready && m_q.size() == 1;
      if (busy && itr_ready) void'(m_q.pop_front());
      if (bus.dbg_wr_en) begin
        case (a)
          4'd0: begin
            m_halt = d[0];
            if (d[2]) m_err = 1'b0;
          end
          4'd2, 4'd3, 4'd4, 4'd5: begin
            if (busy) m_err = 1'b1;
            else begin
              m_itr[int'(a) - 2] = d;
              if (a == 4'd5) begin
                if (core_halted)
                  for (int i = 0; i < 4; i++) m_q.push_back('{m_itr[i], 30'(BASE >> 2) + 30'(i)});
                else m_err = 1'b1;
              end
            end
          end
          4'd6: if (!core_dtr_wr_en) m_dtr[63:32] = d;
          4'd7: if (!core_dtr_wr_en) m_dtr[31:0] = d;
          default: ;
        endcase
      end
      if (core_dtr_wr_en) m_dtr = core_dtr_wdata;
      m_rdata = n_rdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.dbg_wr_en = 1'b1; bus.dbg_addr = a; bus.dbg_wdata = d;
    step_cyc();
    bus.dbg_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    bus.dbg_rd_en = 1'b1; bus.dbg_addr = a;
    step_cyc();
    bus.dbg_rd_en = 1'b0;
  endtask

  task automatic load_itr(input logic [31:0] i0, i1, i2, i3);
    wr(4'd2, i0); wr(4'd3, i1); wr(4'd4, i2); wr(4'd5, i3);
  endtask

  task automatic run_until_done(input int budget);
    int start_cnt;
    start_cnt = done_cnt;
    for (int i = 0; i < budget && done_cnt == start_cnt; i++) step_cyc();
    chk("done_seen", done_cnt != start_cnt, 1'b1);
  endtask

  initial begin
    int prev;
    rst = 1'b1; core_halted = 1'b1; itr_ready = 1'b1;
    core_dtr_wr_en = 1'b0; core_dtr_wdata = '0;
    bus.dbg_wr_en = 1'b0; bus.dbg_rd_en = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    @(posedge clk); #1;
    model_reset();
    step_cyc();
    rst = 1'b0;
    chk("rst_itr_out", itr_out, '0);
    chk("rst_ctrl", {halt_req, resume_pulse, step_pulse, itr_done, itr_err, bus.dbg_busy}, '0);
    chk("rst_rdata", bus.dbg_rdata, 32'h0);

    // DTR round trip
    wr(4'd6, 32'hDEADBEEF);
    wr(4'd7, 32'h12345678);
    chk("dtr_rt", core_dtr_rdata, 64'hDEADBEEF12345678);
    rd(4'd6); chk("rd_hi", bus.dbg_rdata, 32'hDEADBEEF);
    rd(4'd7); chk("rd_lo", bus.dbg_rdata, 32'h12345678);
    rd(4'd9); chk("rd_unmapped", bus.dbg_rdata, 32'h0);

    // Run control pulses, with and without the core halted
    wr(4'd1, 32'h3);
    chk("resume_on", resume_pulse, 1'b1); chk("step_on", step_pulse, 1'b1);
    step_cyc();
    chk("resume_off", resume_pulse, 1'b0);
    core_halted = 1'b0;
    wr(4'd1, 32'h3);
    chk("resume_supp", {resume_pulse, step_pulse}, 2'b00);
    core_halted = 1'b1;

    // Injection with a two-cycle stall on slot 1
    acc.delete(); done_cnt = 0;
    load_itr(32'h13, 32'h93, 32'h113, 32'h193);
    chk("slot0_valid", itr_out.valid, 1'b1);
    step_cyc();
    itr_ready = 1'b0;
    step_cyc(); step_cyc();
    chk("stall_insn", itr_out.insn, 32'h93);
    itr_ready = 1'b1;
    run_until_done(10);
    chk("acc_n", acc.size(), 4);
    for (int i = 0; i < 4 && i < acc.size(); i++) begin
      chk("acc_insn", acc[i].insn, 32'h13 + 32'(i) * 32'h80);
      chk("acc_addr", acc[i].addr, 30'h400 + 30'(i));
    end
    step_cyc(); step_cyc();
    chk("done_once", done_cnt, 1);

    // Illegal injection while the core runs
    core_halted = 1'b0;
    wr(4'd5, 32'h77);
    chk("illegal_valid", itr_out.valid, 1'b0);
    chk("illegal_err", itr_err, 1'b1);
    rd(4'd0); chk("dbgsc_err", bus.dbg_rdata, 32'h4);
    wr(4'd0, 32'h4); chk("err_clear", itr_err, 1'b0);
    core_halted = 1'b1;

    // ITR write while busy is dropped
    acc.delete();
    itr_ready = 1'b0;
    load_itr(32'h13, 32'h93, 32'h113, 32'h193);
    wr(4'd3, 32'hBAD);
    chk("busy_err", itr_err, 1'b1);
    itr_ready = 1'b1;
    run_until_done(10);
    chk("busy_slot1", acc.size() > 1 ? acc[1].insn : 32'hFFFF_FFFF, 32'h93);
    wr(4'd0, 32'h4);

    // Simultaneous core and debug DTR writes
    core_dtr_wr_en = 1'b1; core_dtr_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
    wr(4'd7, 32'h55);
    core_dtr_wr_en = 1'b0;
    chk("dtr_conflict", core_dtr_rdata, 64'hAAAA_AAAA_AAAA_AAAA);

    // Reset in the middle of an injection
    wr(4'd0, 32'h1);
    load_itr(32'h1, 32'h2, 32'h3, 32'h4);
    step_cyc(); step_cyc();
    chk("pre_rst_addr", itr_out.addr, 30'h402);
    rst = 1'b1;
    step_cyc();
    rst = 1'b0;
    chk("rst_mid", {itr_out.valid, bus.dbg_busy, halt_req}, 3'b000);
    prev = done_cnt;
    step_cyc(); step_cyc(); step_cyc();
    chk("rst_no_done", done_cnt, prev);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 299) == 0);
      core_halted    = ($urandom_range(0, 3) != 0);
      itr_ready      = $urandom_range(0, 1);
      core_dtr_wr_en = ($urandom_range(0, 7) == 0);
      core_dtr_wdata = {$urandom, $urandom};
      bus.dbg_wr_en  = ($urandom_range(0, 2) == 0);
      bus.dbg_rd_en  = ($urandom_range(0, 2) == 0);
      bus.dbg_addr   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) bus.dbg_addr = 4'($urandom_range(0, 7));
      bus.dbg_wdata  = $urandom;
      step_cyc();
    end
    rst = 1'b0; bus.dbg_wr_en = 1'b0; bus.dbg_rd_en = 1'b0; core_dtr_wr_en = 1'b0;
    itr_ready = 1'b1;
    for (int i = 0; i < 6; i++) step_cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
